rs_input_conditioner: RTL and testbench
=======================================

# rs_input_conditioner

- Sits directly upstream of the cross-coupled RS latch on the lab board.
- Takes the raw, bouncing S and R slide switches and brings them into the clock domain with a two-flop synchronizer.
- Debounces each switch with a per-channel counter, then drives clean S/R levels into the latch.
- Also produces one-cycle rise pulses and an LED warning when the forbidden S=R=1 input combination is present.

## Interface

Parameters:
- DEBOUNCE_CYCLES, default 500000: consecutive cycles a synchronized input must differ from the stable value before the stable value follows it. 10 ms at 50 MHz. Legal range is 2 or more.
- CNT_W, default $clog2(DEBOUNCE_CYCLES): counter width.

Ports:
- clk  in  1  board clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- sw1_S  in  1  raw set switch, asynchronous to clk.
- sw2_R  in  1  raw reset switch, asynchronous to clk.
- s_clean  out  1  debounced set level. Feeds the latch set input.
- r_clean  out  1  debounced reset level. Feeds the latch reset input.
- s_rise  out  1  one-cycle pulse on a 0→1 transition of s_clean.
- r_rise  out  1  one-cycle pulse on a 0→1 transition of r_clean.
- led7_err  out  1  high while s_clean and r_clean are both 1 (forbidden latch input).

## Operation

- The two channels are identical and independent. Per channel:
  - Synchronizer: sync1 ← raw; sync2 ← sync1.
  - Stable register `stable`, drives the *_clean output. Counter `cnt`, CNT_W bits.
- Per-channel state machine (implicit in cnt):
  - IDLE: sync2 == stable. cnt ← 0.
  - COUNTING: sync2 != stable.
    - If cnt == DEBOUNCE_CYCLES−1: stable ← sync2 and cnt ← 0.
    - Otherwise cnt ← cnt+1.
- A return of sync2 to the stable value while COUNTING aborts the count. cnt ← 0 and stable is unchanged. Glitches of fewer than DEBOUNCE_CYCLES synchronized cycles never reach the output.
- The counter never wraps: its maximum value is DEBOUNCE_CYCLES−1, which fits in CNT_W.
- *_rise is registered and asserts on the same edge that stable goes 0→1, for exactly one cycle. A 1→0 transition produces no pulse.
- led7_err = s_clean & r_clean, combinational from the registered levels, so it is glitch-free.
- Both channels changing in the same cycle is legal. Each updates independently, so s_rise and r_rise may assert together.
- Reset (rst_n low, at any time including mid-count) immediately clears:
  - sync1, sync2, stable, cnt and rise on both channels.
  - All outputs read 0 during reset.
- After reset release, a switch already high is treated as a fresh 0→1 change. It is debounced normally and produces one rise pulse.

## Timing

- Edge E0 is the first clock edge that samples a new raw level into sync1.
  - sync2 takes the new level at E1.
  - cnt counts from E2 to E(DEBOUNCE_CYCLES).
  - stable and *_rise update at E(DEBOUNCE_CYCLES+1).
- Latency from the raw level change to the clean output: DEBOUNCE_CYCLES+2 edges, provided the level is held throughout.
- *_rise is high for exactly the one cycle following E(DEBOUNCE_CYCLES+1).
- led7_err follows the later of the two clean levels with zero additional cycles.
- Reset assertion takes effect asynchronously with no clock required. Deassertion is expected to be synchronous to clk.

## Structure

- Shared package rs_lab_pkg holds:
  - the default DEBOUNCE_CYCLES constant;
  - a reduced simulation constant, SIM_DEBOUNCE_CYCLES = 4.
- One sub-module, debounce_channel, instantiated twice. It contains the synchronizer, the counter, the stable register and rise-pulse generation.
- The top level contains only the two instances and the led7_err AND.
- No other logic lives in the top level.

## Test plan

All scenarios use DEBOUNCE_CYCLES = 4.

1. Reset mid-count:
   - Stimulus: sw1_S held 1, rst_n pulsed low after 3 cycles.
   - Required response: all outputs 0 immediately. After release, s_clean rises 6 edges later with a single s_rise pulse.
2. Clean step:
   - Stimulus: sw1_S 0→1, held.
   - Required response: s_clean = 1 exactly at E5 (6th edge counted from E0). s_rise high for one cycle at the same point. r_clean, r_rise and led7_err stay 0.
3. Bounce rejection:
   - Stimulus: sw2_R toggles 1,0,1,0 at 2-cycle intervals, then returns to 0.
   - Required response: r_clean never leaves 0. r_rise never asserts.
4. Bounce then settle:
   - Stimulus: sw2_R bounces for 3 cycles, then holds 1.
   - Required response: r_clean = 1 exactly 6 edges after the last transition to 1. Exactly one r_rise pulse.
5. Forbidden input:
   - Stimulus: sw1_S and sw2_R both set to 1 in the same cycle.
   - Required response: s_rise and r_rise pulse together. led7_err = 1 until either switch is debounced back to 0.
6. Fall has no pulse:
   - Stimulus: s_clean = 1, then sw1_S → 0, held.
   - Required response: s_clean = 0 after 6 edges. s_rise stays 0.

Source files
------------

// File: rtl/rs_lab_pkg.sv
// rtl/rs_lab_pkg.sv - shared constants for the RS latch lab input path
package rs_lab_pkg;

    // 10 ms at a 50 MHz board clock
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int SIM_DEBOUNCE_CYCLES     = 4;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - two-flop synchronizer, debounce counter, clean level and rise pulse
module debounce_channel
    import rs_lab_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic clean,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic             rise_q;
    logic [CNT_W-1:0] cnt;

    // cnt is only nonzero while sync2 disagrees with stable; any agreement aborts the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            rise_q <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            rise_q <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= sync2;
                rise_q <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign clean = stable;
    assign rise  = rise_q;

endmodule

// File: rtl/rs_input_conditioner.sv
// rtl/rs_input_conditioner.sv - debounced S/R switch conditioning ahead of the lab RS latch
module rs_input_conditioner
    import rs_lab_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw1_S,
    input  logic sw2_R,
    output logic s_clean,
    output logic r_clean,
    output logic s_rise,
    output logic r_rise,
    output logic led7_err
);

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_set (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (sw1_S),
        .clean (s_clean),
        .rise  (s_rise)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_reset (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (sw2_R),
        .clean (r_clean),
        .rise  (r_rise)
    );

    // Both inputs are registered levels, so the warning LED cannot glitch
    assign led7_err = s_clean & r_clean;

endmodule

// File: tb/tb_rs_input_conditioner.sv
// tb/tb_rs_input_conditioner.sv - scoreboard bench for rs_input_conditioner
module tb_rs_input_conditioner;
    import rs_lab_pkg::*;

    localparam int D   = SIM_DEBOUNCE_CYCLES;
    // Edge index (E0 = first edge sampling the new raw level) at which clean outputs update
    localparam int LAT = D + 1;

    logic clk = 1'b0;
    logic rst_n;
    logic sw1_S;
    logic sw2_R;
    logic s_clean, r_clean, s_rise, r_rise, led7_err;

    logic [4:0] exp_q[$];
    logic [4:0] obs;
    logic [4:0] expv;
    int n_vec  = 0;
    int n_miss = 0;

    rs_input_conditioner #(
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw1_S    (sw1_S),
        .sw2_R    (sw2_R),
        .s_clean  (s_clean),
        .r_clean  (r_clean),
        .s_rise   (s_rise),
        .r_rise   (r_rise),
        .led7_err (led7_err)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] vec(bit s, bit r, bit sr, bit rr, bit led);
        return {s, r, sr, rr, led};
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        sw1_S = 1'b1;
        sw2_R = 1'b1;
        for (int k = 0; k < 4; k++) exp_q.push_back(vec(0, 0, 0, 0, 0));
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            obs = {s_clean, r_clean, s_rise, r_rise, led7_err};
            expv = exp_q.pop_front();
            n_vec++;
            if (obs !== expv) begin
                n_miss++;
                $display("FAIL reset_hold k=%0d got=%b exp=%b", k, obs, expv);
            end
        end
    endtask

    task automatic test_reset_mid_count;
        @(negedge clk);
        sw2_R = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) exp_q.push_back(vec(0, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            obs = {s_clean, r_clean, s_rise, r_rise, led7_err};
            expv = exp_q.pop_front();
            n_vec++;
            if (obs !== expv) begin
                n_miss++;
                $display("FAIL mid_count_pre k=%0d got=%b exp=%b", k, obs, expv);
            end
        end
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.push_back(vec(0, 0, 0, 0, 0));
        #1;
        obs = {s_clean, r_clean, s_rise, r_rise, led7_err};
        expv = exp_q.pop_front();
        n_vec++;
        if (obs !== expv) begin
            n_miss++;
            $display("FAIL mid_count_reset got=%b exp=%b", obs, expv);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++)
            exp_q.push_back(vec(k >= LAT, 0, k == LAT, 0, 0));
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            obs = {s_clean, r_clean, s_rise, r_rise, led7_err};
            expv = exp_q.pop_front();
            n_vec++;
            if (obs !== expv) begin
                n_miss++;
                $display("FAIL reset_release_step k=%0d got=%b exp=%b", k, obs, expv);
            end
        end
        // s_clean is 1 here, so an asynchronous clear is observable between edges
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.push_back(vec(0, 0, 0, 0, 0));
        #1;
        obs = {s_clean, r_clean, s_rise, r_rise, led7_err};
        expv = exp_q.pop_front();
        n_vec++;
        if (obs !== expv) begin
            n_miss++;
            $display("FAIL async_clear got=%b exp=%b", obs, expv);
        end
        sw1_S = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) exp_q.push_back(vec(0, 0, 0, 0, 0));
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            obs = {s_clean, r_clean, s_rise, r_rise, led7_err};
            expv = exp_q.pop_front();
            n_vec++;
            if (obs !== expv) begin
                n_miss++;
                $display("FAIL post_reset_idle k=%0d got=%b exp=%b", k, obs, expv);
            end
        end
    endtask

    task automatic test_clean_step;
        @(negedge clk);
        sw1_S = 1'b1;
        for (int k = 0; k < 10; k++)
            exp_q.push_back(vec(k >= LAT, 0, k == LAT, 0, 0));
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            obs = {s_clean, r_clean, s_rise, r_rise, led7_err};
            expv = exp_q.pop_front();
            n_vec++;
            if (obs !== expv) begin
                n_miss++;
                $display("FAIL clean_step k=%0d got=%b exp=%b", k, obs, expv);
            end
        end
    endtask

    task automatic test_fall_no_pulse;
        @(negedge clk);
        sw1_S = 1'b0;
        for (int k = 0; k < 10; k++)
            exp_q.push_back(vec(k < LAT, 0, 0, 0, 0));
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            obs = {s_clean, r_clean, s_rise, r_rise, led7_err};
            expv = exp_q.pop_front();
            n_vec++;
            if (obs !== expv) begin
                n_miss++;
                $display("FAIL fall_no_pulse k=%0d got=%b exp=%b", k, obs, expv);
            end
        end
    endtask

    task automatic test_bounce_reject;
        bit pat [14];
        pat = '{1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int k = 0; k < 14; k++) exp_q.push_back(vec(0, 0, 0, 0, 0));
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            sw2_R = pat[k];
            @(posedge clk); #1;
            obs = {s_clean, r_clean, s_rise, r_rise, led7_err};
            expv = exp_q.pop_front();
            n_vec++;
            if (obs !== expv) begin
                n_miss++;
                $display("FAIL bounce_reject k=%0d got=%b exp=%b", k, obs, expv);
            end
        end
    endtask

    task automatic test_bounce_settle;
        bit pat [14];
        int last_rise;
        pat = '{1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        last_rise = 0;
        for (int k = 1; k < 14; k++)
            if (pat[k] && !pat[k-1]) last_rise = k;
        for (int k = 0; k < 14; k++)
            exp_q.push_back(vec(0, k >= last_rise + LAT, 0, k == last_rise + LAT, 0));
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            sw2_R = pat[k];
            @(posedge clk); #1;
            obs = {s_clean, r_clean, s_rise, r_rise, led7_err};
            expv = exp_q.pop_front();
            n_vec++;
            if (obs !== expv) begin
                n_miss++;
                $display("FAIL bounce_settle k=%0d got=%b exp=%b", k, obs, expv);
            end
        end
        @(negedge clk);
        sw2_R = 1'b0;
        for (int k = 0; k < 10; k++)
            exp_q.push_back(vec(0, k < LAT, 0, 0, 0));
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            obs = {s_clean, r_clean, s_rise, r_rise, led7_err};
            expv = exp_q.pop_front();
            n_vec++;
            if (obs !== expv) begin
                n_miss++;
                $display("FAIL r_fall k=%0d got=%b exp=%b", k, obs, expv);
            end
        end
    endtask

    task automatic test_forbidden;
        @(negedge clk);
        sw1_S = 1'b1;
        sw2_R = 1'b1;
        for (int k = 0; k < 10; k++)
            exp_q.push_back(vec(k >= LAT, k >= LAT, k == LAT, k == LAT, k >= LAT));
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            obs = {s_clean, r_clean, s_rise, r_rise, led7_err};
            expv = exp_q.pop_front();
            n_vec++;
            if (obs !== expv) begin
                n_miss++;
                $display("FAIL forbidden_set k=%0d got=%b exp=%b", k, obs, expv);
            end
        end
        @(negedge clk);
        sw1_S = 1'b0;
        for (int k = 0; k < 10; k++)
            exp_q.push_back(vec(k < LAT, 1, 0, 0, k < LAT));
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            obs = {s_clean, r_clean, s_rise, r_rise, led7_err};
            expv = exp_q.pop_front();
            n_vec++;
            if (obs !== expv) begin
                n_miss++;
                $display("FAIL forbidden_clear k=%0d got=%b exp=%b", k, obs, expv);
            end
        end
        @(negedge clk);
        sw2_R = 1'b0;
        for (int k = 0; k < 10; k++)
            exp_q.push_back(vec(0, k < LAT, 0, 0, 0));
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            obs = {s_clean, r_clean, s_rise, r_rise, led7_err};
            expv = exp_q.pop_front();
            n_vec++;
            if (obs !== expv) begin
                n_miss++;
                $display("FAIL forbidden_release k=%0d got=%b exp=%b", k, obs, expv);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired: bench did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        sw1_S = 1'b0;
        sw2_R = 1'b0;
        test_reset();
        test_reset_mid_count();
        test_clean_step();
        test_fall_no_pulse();
        test_bounce_reject();
        test_bounce_settle();
        test_forbidden();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
